// File: rtl/keycode_event_scheduler.sv
// rtl/keycode_event_scheduler.sv - keycode snapshot diff into ordered press/release event stream
// Optional auto-repeat is built when KEYEVT_REPEAT_EN is defined.

module keycode_event_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 9
) (
    input  logic                   clk,
    input  logic                   reset_n,
    input  logic                   s_tvalid,
    input  logic [W-1:0]           s_tdata,
    output logic                   s_tready,
    output logic                   m_tvalid,
    output logic [W-1:0]           m_tdata,
    input  logic                   m_tready,
    output logic [$clog2(DEPTH):0] count
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push;
    logic          pop;

    // a full FIFO refuses the push even if the head is popped this cycle
    assign s_tready = (count != (PW+1)'(DEPTH));
    assign m_tvalid = (count != '0);
    assign push     = s_tvalid && s_tready;
    assign pop      = m_tvalid && m_tready;
    assign m_tdata  = m_tvalid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (!push && pop)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= s_tdata;
    end
endmodule

module keycode_event_scheduler #(
    parameter int FIFO_DEPTH    = 8
`ifdef KEYEVT_REPEAT_EN
    ,
    parameter int REPEAT_DELAY  = 25000000,
    parameter int REPEAT_PERIOD = 2500000
`endif
) (
    input  logic                        clk,
    input  logic                        reset_n,
    input  logic [31:0]                 keycode_in,
    output logic                        evt_valid,
    input  logic                        evt_ready,
    output logic [7:0]                  evt_code,
    output logic                        evt_press,
    output logic                        evt_repeat,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count,
    output logic                        busy
);
`ifdef KEYEVT_REPEAT_EN
    localparam int EW = 10;
`else
    localparam int EW = 9;
`endif

    typedef enum logic [1:0] {IDLE, SCAN, COMMIT} state_t;

    state_t        state;
    logic [31:0]   committed;
    logic [31:0]   snap;
    logic [2:0]    slot;
    logic          busy_q;
    logic [31:0]   own_word;
    logic [31:0]   other_word;
    logic [7:0]    cand;
    logic          hit;
    logic          fifo_tvalid;
    logic [EW-1:0] fifo_tdata;
    logic          fifo_tready;
    logic [EW-1:0] head;

    function automatic logic has_code(input logic [31:0] w, input logic [7:0] c);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 4; i++)
            if (w[i*8 +: 8] == c)
                found = 1'b1;
        return found;
    endfunction

    function automatic logic seen_below(input logic [31:0] w, input logic [1:0] k);
        logic found;
        found = 1'b0;
        for (int i = 0; i < 3; i++)
            if (i < int'(k) && w[i*8 +: 8] == w[{k, 3'b000} +: 8])
                found = 1'b1;
        return found;
    endfunction

    // slots 0-3 look for releases in committed, slots 4-7 for presses in snap
    assign own_word   = slot[2] ? snap : committed;
    assign other_word = slot[2] ? committed : snap;
    assign cand       = own_word[{slot[1:0], 3'b000} +: 8];
    assign hit        = (state == SCAN) && (cand != 8'h00) &&
                        !has_code(other_word, cand) && !seen_below(own_word, slot[1:0]);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            committed <= '0;
            snap      <= '0;
            slot      <= '0;
            busy_q    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (keycode_in != committed) begin
                        snap   <= keycode_in;
                        slot   <= '0;
                        busy_q <= 1'b1;
                        state  <= SCAN;
                    end
                end
                SCAN: begin
                    if (!hit || fifo_tready) begin
                        if (slot == 3'd7)
                            state <= COMMIT;
                        else
                            slot <= slot + 1'b1;
                    end
                end
                COMMIT: begin
                    committed <= snap;
                    busy_q    <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef KEYEVT_REPEAT_EN
    localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW   = $clog2(RMAX + 1);

    logic [7:0]    rep_key;
    logic [RW-1:0] rep_cnt;
    logic          rep_first;
    logic [RW-1:0] rep_target;
    logic          rep_fire;
    logic          scan_push;

    assign scan_push  = hit && fifo_tready;
    assign rep_target = rep_first ? RW'(REPEAT_DELAY) : RW'(REPEAT_PERIOD);
    assign rep_fire   = (state == IDLE) && (rep_key != 8'h00) && (rep_cnt + 1'b1 == rep_target);

    // an expiry against a full FIFO is dropped, but the period restarts anyway
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rep_key   <= '0;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (scan_push && slot[2]) begin
            rep_key   <= cand;
            rep_cnt   <= '0;
            rep_first <= 1'b1;
        end else if (scan_push && cand == rep_key) begin
            rep_key <= '0;
        end else if (state == IDLE && rep_key != 8'h00) begin
            if (rep_fire) begin
                rep_cnt   <= '0;
                rep_first <= 1'b0;
            end else begin
                rep_cnt <= rep_cnt + 1'b1;
            end
        end
    end

    assign fifo_tvalid = hit || rep_fire;
    assign fifo_tdata  = hit ? {cand, slot[2], 1'b0} : {rep_key, 1'b1, 1'b1};
    assign {evt_code, evt_press, evt_repeat} = head;
`else
    assign fifo_tvalid = hit;
    assign fifo_tdata  = {cand, slot[2]};
    assign {evt_code, evt_press} = head;
    assign evt_repeat  = 1'b0;
`endif

    assign busy = busy_q;

    keycode_event_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (EW)
    ) u_fifo (
        .clk      (clk),
        .reset_n  (reset_n),
        .s_tvalid (fifo_tvalid),
        .s_tdata  (fifo_tdata),
        .s_tready (fifo_tready),
        .m_tvalid (evt_valid),
        .m_tdata  (head),
        .m_tready (evt_ready),
        .count    (fifo_count)
    );
endmodule

// File: tb/tb_keycode_event_scheduler.sv
// tb/tb_keycode_event_scheduler.sv - randomized bench with set-level event model for keycode_event_scheduler
`timescale 1ns/1ps

module tb_keycode_event_scheduler;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] keycode_in = '0;
    logic        evt_valid;
    logic        evt_ready = 1'b0;
    logic [7:0]  evt_code;
    logic        evt_press;
    logic        evt_repeat;
    logic [$clog2(DEPTH):0] fifo_count;
    logic        busy;

    always #5 clk = ~clk;

    keycode_event_scheduler #(
        .FIFO_DEPTH (DEPTH)
`ifdef KEYEVT_REPEAT_EN
        ,
        .REPEAT_DELAY  (10),
        .REPEAT_PERIOD (4)
`endif
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .keycode_in (keycode_in),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_code   (evt_code),
        .evt_press  (evt_press),
        .evt_repeat (evt_repeat),
        .fifo_count (fifo_count),
        .busy       (busy)
    );

    typedef struct packed {
        logic [7:0] code;
        logic       press;
    } ev_t;
    typedef ev_t        ev_q_t[$];
    typedef logic [7:0] code_q_t[$];

    ev_q_t       expq;
    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          ready_mode = 0;   // 0 always ready, 1 never ready, 2 random
    logic [31:0] model_committed = '0;
    int          rep_times[$];
    logic        prev_valid = 1'b0;
    logic        prev_ready = 1'b0;
    logic [9:0]  prev_head = '0;

    always @(posedge clk) cyc++;

    function automatic logic in_q(input code_q_t q, input logic [7:0] c);
        foreach (q[i])
            if (q[i] == c)
                return 1'b1;
        return 1'b0;
    endfunction

    // distinct nonzero codes of a snapshot in first-appearance order
    function automatic code_q_t uniq(input logic [31:0] w);
        code_q_t u;
        for (int i = 0; i < 4; i++) begin
            logic [7:0] c;
            c = w[i*8 +: 8];
            if (c != 8'h00 && !in_q(u, c))
                u.push_back(c);
        end
        return u;
    endfunction

    function automatic ev_q_t diff(input logic [31:0] old_w, input logic [31:0] new_w);
        code_q_t uo;
        code_q_t un;
        ev_q_t   r;
        uo = uniq(old_w);
        un = uniq(new_w);
        foreach (uo[i])
            if (!in_q(un, uo[i]))
                r.push_back({uo[i], 1'b0});
        foreach (un[i])
            if (!in_q(uo, un[i]))
                r.push_back({un[i], 1'b1});
        return r;
    endfunction

    function automatic logic [63:0] pack_q(input ev_q_t q);
        logic [63:0] acc;
        acc = '0;
        foreach (q[i])
            acc = (acc << 9) | 64'(q[i]);
        acc[63:56] = 8'(q.size());
        return acc;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic apply(input logic [31:0] v);
        ev_q_t d;
        d = diff(model_committed, v);
        foreach (d[i])
            expq.push_back(d[i]);
        model_committed = v;
        keycode_in = v;
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        @(negedge clk);
        while (busy && n < 3000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 3000)
            check("wait_idle_timeout", 64'(n), 64'(0));
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((expq.size() != 0 || busy) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_pending_events", 64'(expq.size()), 64'(0));
        repeat (3) @(negedge clk);
    endtask

    // per-cycle compare of the head against the model queue; also drives evt_ready
    always @(negedge clk) begin
        logic nr;
        if (reset_n) begin
            tests++;
            if (evt_valid !== (fifo_count != 0)) begin
                fails++;
                $display("FAIL valid_vs_count: valid=%0b count=%0d", evt_valid, fifo_count);
            end
            if (prev_valid && !prev_ready) begin
                tests++;
                if (!evt_valid || {evt_code, evt_press, evt_repeat} !== prev_head) begin
                    fails++;
                    $display("FAIL head_stable: got valid=%0b head=0x%0h, required 0x%0h",
                             evt_valid, {evt_code, evt_press, evt_repeat}, prev_head);
                end
            end
            if (evt_valid) begin
                tests++;
                if (evt_repeat) begin
`ifdef KEYEVT_REPEAT_EN
                    rep_times.push_back(cyc);
                    if (!evt_press || evt_code == 8'h00) begin
                        fails++;
                        $display("FAIL repeat_shape: code=0x%0h press=%0b", evt_code, evt_press);
                    end
`else
                    fails++;
                    $display("FAIL repeat_bit: got 1, required 0");
`endif
                end else if (expq.size() == 0) begin
                    fails++;
                    $display("FAIL unexpected_event: code=0x%0h press=%0b, none expected", evt_code, evt_press);
                end else if ({evt_code, evt_press} !== expq[0]) begin
                    fails++;
                    $display("FAIL event: got code=0x%0h press=%0b, required code=0x%0h press=%0b",
                             evt_code, evt_press, expq[0].code, expq[0].press);
                end
            end
        end
        nr = (ready_mode == 0) ? 1'b1 : (ready_mode == 1) ? 1'b0 : 1'($urandom_range(0, 1));
        evt_ready = nr;
        if (reset_n && evt_valid && nr && !evt_repeat && expq.size() > 0)
            void'(expq.pop_front());
        prev_valid = reset_n && evt_valid;
        prev_ready = nr;
        prev_head  = {evt_code, evt_press, evt_repeat};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_v;
        int busy_cnt;
        int busy_seen;
        int n;
        logic [31:0] v;

        check("model_diff_1a_to_0704", pack_q(diff(32'h0000001A, 32'h00000704)), 64'h0300_0000_00D0_120F);
        check("model_diff_dup_press", pack_q(diff(32'h0, 32'h1A1A0000)), 64'h0100_0000_0000_0035);
        check("model_diff_dup_release", pack_q(diff(32'h1A1A0000, 32'h0)), 64'h0100_0000_0000_0034);

        ready_mode = 0;
        repeat (3) @(negedge clk);
        check("rst_evt_valid", 64'(evt_valid), 64'(0));
        check("rst_evt_code", 64'(evt_code), 64'(0));
        check("rst_evt_press", 64'(evt_press), 64'(0));
        check("rst_evt_repeat", 64'(evt_repeat), 64'(0));
        check("rst_fifo_count", 64'(fifo_count), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // single press latency and busy window
        @(negedge clk);
        apply(32'h0000001A);
        first_v  = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (busy)
                busy_cnt++;
            if (evt_valid && first_v < 0)
                first_v = k;
        end
        check("first_valid_latency", 64'(first_v), 64'(6));
        check("busy_cycles", 64'(busy_cnt), 64'(9));
        drain();

        wait_idle();
        apply(32'h00000704);
        drain();
        wait_idle();
        apply(32'h00000704);
        busy_seen = 0;
        repeat (6) begin
            @(negedge clk);
            if (busy)
                busy_seen++;
        end
        check("committed_same_no_scan", 64'(busy_seen), 64'(0));

        wait_idle();
        apply(32'h1A1A0000);
        drain();
        wait_idle();
        apply(32'h00000000);
        drain();

        // backpressure: full FIFO stalls the scan, nothing is lost
        wait_idle();
        apply(32'h0A0B0C0D);
        drain();
        wait_idle();
        ready_mode = 1;
        @(negedge clk);
        apply(32'h04070816);
        repeat (30) @(negedge clk);
        check("stall_fifo_count", 64'(fifo_count), 64'(DEPTH));
        check("stall_busy", 64'(busy), 64'(1));
        ready_mode = 0;
        drain();

        // input change mid-scan is picked up by a second scan
        ready_mode = 2;
        wait_idle();
        apply(32'h00000000);
        drain();
        wait_idle();
        apply(32'h11220000);
        repeat (3) @(negedge clk);
        check("midscan_busy", 64'(busy), 64'(1));
        apply(32'h00003311);
        drain();

        // asynchronous reset mid-scan
        ready_mode = 1;
        wait_idle();
        apply(32'h01020304);
        n = 0;
        while (fifo_count < 2 && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("reset_prefill_count", 64'(fifo_count), 64'(2));
        #2 reset_n = 1'b0;
        #1;
        check("midrst_evt_valid", 64'(evt_valid), 64'(0));
        check("midrst_evt_code", 64'(evt_code), 64'(0));
        check("midrst_evt_press", 64'(evt_press), 64'(0));
        check("midrst_evt_repeat", 64'(evt_repeat), 64'(0));
        check("midrst_fifo_count", 64'(fifo_count), 64'(0));
        check("midrst_busy", 64'(busy), 64'(0));
        expq.delete();
        model_committed = '0;
        @(negedge clk);
        #2 reset_n = 1'b1;
        ready_mode = 0;
        apply(keycode_in);
        drain();

        // randomized snapshots with duplicates and random backpressure
        ready_mode = 2;
        for (int it = 0; it < 60; it++) begin
            wait_idle();
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 2) == 0)
                    v[b*8 +: 8] = model_committed[b*8 +: 8];
                else
                    v[b*8 +: 8] = 8'($urandom_range(0, 6));
            end
            apply(v);
        end
        drain();

`ifdef KEYEVT_REPEAT_EN
        ready_mode = 0;
        wait_idle();
        apply(32'h00000000);
        drain();
        wait_idle();
        rep_times.delete();
        n = cyc;
        apply(32'h00000004);
        repeat (30) @(negedge clk);
        apply(32'h00000000);
        repeat (60) @(negedge clk);
        check("repeat_count", 64'(rep_times.size()), 64'(3));
        if (rep_times.size() >= 3) begin
            check("repeat_first", 64'(rep_times[0] - n), 64'(20));
            check("repeat_second", 64'(rep_times[1] - n), 64'(24));
            check("repeat_third", 64'(rep_times[2] - n), 64'(28));
        end
        drain();
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
